serial_launch_tx: RTL and testbench

- Transmit end of the bit-serial capture interface used by the team's negedge-capture flops: async active-high reset, active-low enable.
- Accepts a parallel word over a valid/ready handshake and launches it serially on the rising edge, one bit per cycle, as sdata plus an active-low enable strobe sen_n.
- The downstream receiver samples on the falling edge. sdata/sen_n are therefore stable half a cycle before each sample point.
- Sits between a parallel producer and any chain of negedge enable-low capture flops / deserializers.

---
 rtl/serial_launch_tx.sv | 121 ++++++++++++
 tb/tb_serial_launch_tx.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_launch_tx.sv
// Bit-serial transmitter: accepts a parallel word over valid/ready and launches it
// one bit per rising edge as sdata with an active-low strobe sen_n, for negedge capture.
module serial_launch_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int GAP       = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             sdata,
  output logic             sen_n,
  output logic             busy,
  output logic             done
);

  localparam int CW = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH);
  localparam int GW = ($clog2(GAP + 1) < 1) ? 1 : $clog2(GAP + 1);

  localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    bcnt;
  logic [GW-1:0]    gcnt;

  // The first bit goes straight from in_data to the wire, so the shift register
  // is loaded already advanced by one position; its head is always the next bit.
  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] load_sh;
  logic [WIDTH-1:0] next_sh;

  always_comb begin
    if (MSB_FIRST) begin
      first_bit = in_data[WIDTH-1];
      load_sh   = {in_data[WIDTH-2:0], 1'b0};
      next_bit  = shreg[WIDTH-1];
      next_sh   = {shreg[WIDTH-2:0], 1'b0};
    end else begin
      first_bit = in_data[0];
      load_sh   = {1'b0, in_data[WIDTH-1:1]};
      next_bit  = shreg[0];
      next_sh   = {1'b0, shreg[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      shreg    <= '0;
      bcnt     <= '0;
      gcnt     <= '0;
      in_ready <= 1'b1;
      sdata    <= 1'b0;
      sen_n    <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            shreg    <= load_sh;
            sdata    <= first_bit;
            sen_n    <= 1'b0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            bcnt     <= BIT_LAST;
            state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (bcnt != '0) begin
            sdata <= next_bit;
            shreg <= next_sh;
            bcnt  <= bcnt - CW'(1);
          end else begin
            // last bit has been on the wire a full cycle; close the word
            sen_n <= 1'b1;
            sdata <= 1'b0;
            done  <= 1'b1;
            shreg <= '0;
            if (GAP == 0) begin
              state    <= S_IDLE;
              in_ready <= 1'b1;
              busy     <= 1'b0;
            end else begin
              state <= S_GAP;
              gcnt  <= GAP_LAST;
            end
          end
        end
        S_GAP: begin
          if (gcnt == '0) begin
            state    <= S_IDLE;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end else begin
            gcnt <= gcnt - GW'(1);
          end
        end
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
          sen_n    <= 1'b1;
          sdata    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_launch_tx.sv
// Bench for serial_launch_tx: three configurations (MSB/GAP0, LSB/GAP0, MSB/GAP3) share
// one producer; a cycle-count reference model and negedge loopback capture check them.
module tb_serial_launch_tx;
  localparam int W  = 8;
  localparam int NI = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic [NI-1:0] rdy, sd, sn, bs, dn;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_launch_tx #(.WIDTH(W), .MSB_FIRST(1'b1), .GAP(0)) u_msb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy[0]),
    .sdata(sd[0]), .sen_n(sn[0]), .busy(bs[0]), .done(dn[0]));
  serial_launch_tx #(.WIDTH(W), .MSB_FIRST(1'b0), .GAP(0)) u_lsb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy[1]),
    .sdata(sd[1]), .sen_n(sn[1]), .busy(bs[1]), .done(dn[1]));
  serial_launch_tx #(.WIDTH(W), .MSB_FIRST(1'b1), .GAP(3)) u_gap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy[2]),
    .sdata(sd[2]), .sen_n(sn[2]), .busy(bs[2]), .done(dn[2]));

  function automatic bit msbf(int i);
    return i != 1;
  endfunction

  function automatic int gp(int i);
    return (i == 2) ? 3 : 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: t = cycles since the accepting edge (-1 when idle).
  // Bits occupy t=0..W-1, done at t=W, ready again at t=W+GAP.
  int           t[NI] = '{-1, -1, -1};
  logic [W-1:0] word[NI];

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < NI; i++) begin
      if (rst) t[i] <= -1;
      else if ((t[i] < 0 || t[i] >= W + gp(i)) && in_valid) begin
        t[i]    <= 0;
        word[i] <= in_data;
      end else if (t[i] >= 0 && t[i] < W + gp(i)) t[i] <= t[i] + 1;
      else t[i] <= -1;
    end
  end

  // {in_ready, sdata, sen_n, busy, done}
  function automatic logic [4:0] mexp(int i);
    int   tt;
    logic b;
    tt = t[i];
    if (tt < 0) return 5'b10100;
    if (tt < W) begin
      b = msbf(i) ? word[i][W-1-tt] : word[i][tt];
      return {1'b0, b, 1'b0, 1'b1, 1'b0};
    end
    return {tt == W + gp(i), 1'b0, 1'b1, tt < W + gp(i), tt == W};
  endfunction

  // Loopback: negedge, async-high-reset, enable-low capture shift register
  logic [W-1:0] cap[NI];
  always @(negedge clk or posedge rst) begin
    for (int i = 0; i < NI; i++) begin
      if (rst) cap[i] <= '0;
      else if (!sn[i]) cap[i] <= msbf(i) ? {cap[i][W-2:0], sd[i]} : {sd[i], cap[i][W-1:1]};
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("cycle_out[%0d]", i), {rdy[i], sd[i], sn[i], bs[i], dn[i]}, mexp(i));
      if (dn[i]) chk($sformatf("loopback[%0d]", i), cap[i], word[i]);
    end
  end

  typedef struct {
    logic [7:0] data;
    logic [7:0] msb_seq;  // bits in wire order, first bit at [7]
    logic [7:0] lsb_seq;
  } vec_t;
  vec_t tbl[9];

  task automatic send_collect(input logic [7:0] d, output logic [7:0] ms,
                              output logic [7:0] ls, output int lowcnt);
    @(posedge clk); #1 in_valid = 1'b1; in_data = d;
    @(posedge clk); #1 in_valid = 1'b0; in_data = 8'($urandom);
    ms = '0; ls = '0; lowcnt = 0;
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      ms[W-1-k] = sd[0];
      ls[W-1-k] = sd[1];
      if (!sn[0]) lowcnt++;
    end
    @(negedge clk);
    if (!sn[0]) lowcnt++;
    repeat (6) @(posedge clk);
  endtask

  initial begin
    logic [7:0] ms, ls;
    int         lc;
    int         run[NI], meas[NI];
    bit         seen_low[NI], in_hi[NI], got[NI];

    tbl[0] = '{8'hC4, 8'b11000100, 8'b00100011};
    tbl[1] = '{8'h00, 8'h00, 8'h00};
    tbl[2] = '{8'hFF, 8'hFF, 8'hFF};
    tbl[3] = '{8'h81, 8'h81, 8'h81};
    tbl[4] = '{8'h5A, 8'b01011010, 8'b01011010};
    tbl[5] = '{8'h12, 8'b00010010, 8'b01001000};
    tbl[6] = '{8'h34, 8'b00110100, 8'b00101100};
    tbl[7] = '{8'h0F, 8'b00001111, 8'b11110000};
    tbl[8] = '{8'h01, 8'b00000001, 8'b10000000};

    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      send_collect(tbl[i].data, ms, ls, lc);
      chk($sformatf("msb_seq[%0h]", tbl[i].data), ms, tbl[i].msb_seq);
      chk($sformatf("lsb_seq[%0h]", tbl[i].data), ls, tbl[i].lsb_seq);
      chk($sformatf("sen_low_cycles[%0h]", tbl[i].data), lc, 8);
    end

    // Back-to-back with in_valid held: measure first sen_n-high run per instance
    for (int i = 0; i < NI; i++) begin
      run[i] = 0; meas[i] = -1; seen_low[i] = 0; in_hi[i] = 0; got[i] = 0;
    end
    @(posedge clk); #1 in_valid = 1'b1; in_data = 8'h12;
    @(posedge clk); #1 in_data = 8'h34;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (!sn[i]) begin
          if (in_hi[i] && !got[i]) begin got[i] = 1; meas[i] = run[i]; end
          seen_low[i] = 1; in_hi[i] = 0; run[i] = 0;
        end else if (seen_low[i]) begin
          in_hi[i] = 1; run[i]++;
        end
      end
    end
    #1 in_valid = 1'b0;
    for (int i = 0; i < NI; i++) chk($sformatf("b2b_gap[%0d]", i), meas[i], gp(i) + 1);
    repeat (20) @(posedge clk);

    // Input pulsed during a word must be ignored
    @(posedge clk); #1 in_valid = 1'b1; in_data = 8'h0F;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 in_valid = 1'b1; in_data = 8'hFF;
    @(posedge clk); #1 in_valid = 1'b0;
    chk("ignored_ready", rdy, 3'b000);
    repeat (20) @(posedge clk);

    // Reset between edges after 3 bits of 0xA5
    @(posedge clk); #1 in_valid = 1'b1; in_data = 8'hA5;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < NI; i++)
      chk($sformatf("rst_async[%0d]", i), {rdy[i], sd[i], sn[i], bs[i], dn[i]}, 5'b10100);
    @(posedge clk); #3 rst = 1'b0;
    send_collect(8'h5A, ms, ls, lc);
    chk("after_rst_msb", ms, 8'b01011010);
    chk("after_rst_lsb", ls, 8'b01011010);
    chk("after_rst_low", lc, 8);
    repeat (10) @(posedge clk);

    // Randomized traffic with occasional mid-cycle resets
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = 8'($urandom);
      if ($urandom_range(0, 249) == 0) begin
        #2 rst = 1'b1;
        #3 rst = 1'b0;
      end
    end
    #1 in_valid = 1'b0;
    repeat (20) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
